// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the two-requester shift arbiter: default widths,
// FSM state encoding and shift-direction constants.
package shift_arbiter_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_AMT_W  = 3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/shift_arbiter_shift_lr_unit.sv
// Combinational bidirectional logical shifter shared by both requesters.
module shift_lr_unit
    import shift_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned AMT_W  = DEF_AMT_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [AMT_W-1:0]  amt,
    input  logic              dir,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        if (dir == DIR_RIGHT) begin
            y = a >> amt;
        end else begin
            y = a << amt;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of one shared logical shifter; a 3-state
// FSM accepts one operation, computes it, then holds the result until taken.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned AMT_W  = DEF_AMT_W
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [AMT_W-1:0]  req0_amt,
    input  logic              req0_dir,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [AMT_W-1:0]  req1_amt,
    input  logic              req1_dir,

    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_y,
    output logic              res_id,

    output logic              busy
);

    state_t              state;
    logic                prio;
    logic [DATA_W-1:0]   op_a;
    logic [AMT_W-1:0]    op_amt;
    logic                op_dir;
    logic                op_id;

    logic                idle_c;
    logic                grant_id_c;
    logic                accept_c;
    logic [DATA_W-1:0]   shift_y_c;

    shift_lr_unit #(
        .DATA_W (DATA_W),
        .AMT_W  (AMT_W)
    ) u_shift (
        .a   (op_a),
        .amt (op_amt),
        .dir (op_dir),
        .y   (shift_y_c)
    );

    // Grant and handshake; ready/busy are forced low while reset_n is held low.
    always_comb begin
        idle_c     = reset_n && (state == ST_IDLE);
        grant_id_c = (req0_valid && req1_valid) ? prio : req1_valid;
        accept_c   = idle_c && (req0_valid || req1_valid);
        req0_ready = accept_c && !grant_id_c;
        req1_ready = accept_c && grant_id_c;
        busy       = reset_n && (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            prio      <= 1'b0;
            op_a      <= '0;
            op_amt    <= '0;
            op_dir    <= 1'b0;
            op_id     <= 1'b0;
            res_valid <= 1'b0;
            res_y     <= '0;
            res_id    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        op_a   <= grant_id_c ? req1_a   : req0_a;
                        op_amt <= grant_id_c ? req1_amt : req0_amt;
                        op_dir <= grant_id_c ? req1_dir : req0_dir;
                        op_id  <= grant_id_c;
                        prio   <= !grant_id_c;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_y     <= shift_y_c;
                    res_id    <= op_id;
                    res_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and randomized self-checking bench for shift_arbiter.
module tb_shift_arbiter;

    logic       clk;
    logic       reset_n;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a, req1_a;
    logic [2:0] req0_amt, req1_amt;
    logic       req0_dir, req1_dir;
    logic       res_valid, res_ready;
    logic [7:0] res_y;
    logic       res_id;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model state for the soak phase
    int         mstate;
    logic       mprio;
    logic [8:0] q[$];
    int         accepted;

    shift_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_amt   (req0_amt),
        .req0_dir   (req0_dir),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_amt   (req1_amt),
        .req1_dir   (req1_dir),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_y      (res_y),
        .res_id     (res_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] ref_shift(input logic [7:0] a, input logic [2:0] amt,
                                             input logic dir);
        logic [7:0] y;
        y = 8'h00;
        for (int i = 0; i < 8; i++) begin
            int src;
            src = dir ? (i + int'(amt)) : (i - int'(amt));
            if (src >= 0 && src < 8) y[i] = a[src];
        end
        return y;
    endfunction

    task automatic clear_req();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 8'hEE; req0_amt = 3'd7; req0_dir = 1'b1;
        req1_a = 8'hDD; req1_amt = 3'd7; req1_dir = 1'b0;
    endtask

    // One isolated operation from a single requester, checking latency and result.
    task automatic do_op(input logic id, input logic [7:0] a, input logic [2:0] amt,
                         input logic dir, input logic [7:0] exp_y);
        @(negedge clk);
        clear_req();
        if (!id) begin
            req0_valid = 1'b1; req0_a = a; req0_amt = amt; req0_dir = dir;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_amt = amt; req1_dir = dir;
        end
        #1;
        chk("op_r0", req0_ready, !id);
        chk("op_r1", req1_ready, id);
        chk("op_idle_busy", busy, 1'b0);
        @(negedge clk);
        clear_req();
        #1;
        chk("op_exec_busy", busy, 1'b1);
        chk("op_exec_noval", res_valid, 1'b0);
        @(negedge clk);
        #1;
        chk("op_resp_valid", res_valid, 1'b1);
        chk("op_res_y", res_y, exp_y);
        chk("op_res_id", res_id, id);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chk("op_done_busy", busy, 1'b0);
        chk("op_done_valid", res_valid, 1'b0);
    endtask

    task automatic soak_cycle(input bit gen);
        logic e0, e1;
        @(negedge clk);
        req0_valid = gen ? 1'($urandom_range(0, 1)) : 1'b0;
        req1_valid = gen ? 1'($urandom_range(0, 1)) : 1'b0;
        req0_a = 8'($urandom); req0_amt = 3'($urandom); req0_dir = 1'($urandom);
        req1_a = 8'($urandom); req1_amt = 3'($urandom); req1_dir = 1'($urandom);
        res_ready = gen ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        e0 = (mstate == 0) && req0_valid && (!req1_valid || !mprio);
        e1 = (mstate == 0) && req1_valid && (!req0_valid || mprio);
        chk("soak_r0", req0_ready, e0);
        chk("soak_r1", req1_ready, e1);
        chk("soak_busy", busy, mstate != 0);
        chk("soak_valid", res_valid, mstate == 2);
        if (mstate == 2) begin
            chk("soak_nodup", q.size() != 0, 1'b1);
            if (q.size() != 0) begin
                chk("soak_y", res_y, q[0][7:0]);
                chk("soak_id", res_id, q[0][8]);
                if (res_ready) begin
                    void'(q.pop_front());
                    mstate = 0;
                end
            end
        end else if (mstate == 1) begin
            mstate = 2;
        end else if (e0 || e1) begin
            if (e1) q.push_back({1'b1, ref_shift(req1_a, req1_amt, req1_dir)});
            else    q.push_back({1'b0, ref_shift(req0_a, req0_amt, req0_dir)});
            accepted++;
            mprio  = e0;
            mstate = 1;
        end
    endtask

    initial begin
        int guard;
        reset_n = 1'b0;
        res_ready = 1'b0;
        clear_req();

        // Reset: outputs cleared, no grants even with requests pending
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_r0", req0_ready, 1'b0);
        chk("rst_r1", req1_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_y", res_y, 8'h00);
        chk("rst_id", res_id, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        clear_req();

        // Single requests, left/right and zero-amount shifts
        do_op(1'b0, 8'hB5, 3'd3, 1'b0, 8'hA8);
        do_op(1'b1, 8'hB5, 3'd3, 1'b1, 8'h16);
        do_op(1'b1, 8'hB5, 3'd0, 1'b1, 8'hB5);
        do_op(1'b0, 8'hB5, 3'd0, 1'b0, 8'hB5);
        do_op(1'b0, 8'hFF, 3'd7, 1'b1, 8'h01);

        // Backpressure: result held while res_ready stays low
        @(negedge clk);
        clear_req();
        req1_valid = 1'b1; req1_a = 8'h3C; req1_amt = 3'd2; req1_dir = 1'b0;
        #1;
        chk("bp_grant", req1_ready, 1'b1);
        @(negedge clk);
        clear_req();
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            req0_valid = 1'b1; req1_valid = 1'b1;
            #1;
            chk("bp_valid", res_valid, 1'b1);
            chk("bp_y", res_y, 8'hF0);
            chk("bp_id", res_id, 1'b1);
            chk("bp_r0", req0_ready, 1'b0);
            chk("bp_r1", req1_ready, 1'b0);
            chk("bp_busy", busy, 1'b1);
        end
        @(negedge clk);
        clear_req();
        res_ready = 1'b1;
        #1;
        chk("bp_last_y", res_y, 8'hF0);
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chk("bp_idle_busy", busy, 1'b0);
        chk("bp_idle_valid", res_valid, 1'b0);

        // Reset while in EXEC abandons the op and returns prio to req0
        @(negedge clk);
        clear_req();
        req0_valid = 1'b1; req0_a = 8'h11; req0_amt = 3'd1; req0_dir = 1'b0;
        #1;
        chk("rx_grant", req0_ready, 1'b1);
        @(negedge clk);
        clear_req();
        reset_n = 1'b0;
        res_ready = 1'b1;
        #1;
        chk("rx_busy_in_rst", busy, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rx_valid0", res_valid, 1'b0);
        chk("rx_busy0", busy, 1'b0);
        @(negedge clk);
        #1;
        chk("rx_valid1", res_valid, 1'b0);

        // Contention: both valid, grants alternate starting at req0, 3 cycles apart
        req0_valid = 1'b1; req0_a = 8'h81; req0_amt = 3'd1; req0_dir = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h81; req1_amt = 3'd1; req1_dir = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("ct_r0", req0_ready, (k % 3 == 0) && ((k / 3) % 2 == 0));
            chk("ct_r1", req1_ready, (k % 3 == 0) && ((k / 3) % 2 == 1));
            chk("ct_valid", res_valid, k % 3 == 2);
            if (k % 3 == 2) begin
                chk("ct_id", res_id, (k / 3) % 2);
                chk("ct_y", res_y, ((k / 3) % 2 == 0) ? 8'h02 : 8'h40);
            end
        end
        @(negedge clk);
        clear_req();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Random soak against the reference model and scoreboard
        mstate = 0;
        mprio = 1'b0;
        accepted = 0;
        guard = 0;
        while (accepted < 1000 && guard < 20000) begin
            soak_cycle(1'b1);
            guard++;
        end
        chk("soak_budget", guard < 20000, 1'b1);
        for (int i = 0; i < 10 && mstate != 0; i++) soak_cycle(1'b0);
        chk("soak_drain_empty", q.size(), 0);
        @(negedge clk);
        clear_req();
        #1;
        chk("soak_end_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
